// File: rtl/reg_writeback_arb_pkg.sv
// Shared widths, defaults and types for the regfile writeback arbiter.
package reg_writeback_arb_pkg;

    localparam int unsigned WB_ADDR_W     = 7;
    localparam int unsigned WB_DATA_W     = 64;
    localparam int unsigned WB_FIFO_DEPTH = 4;
    localparam int unsigned WB_STARVE_LIM = 8;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SelNone,
        SelAlu,
        SelLoad
    } wb_sel_e;

endpackage

// File: rtl/reg_writeback_arb_wb_fifo.sv
// Synchronous FIFO of load results {addr, data}; exposes per-entry valid/addr for hazard lookup.
module reg_writeback_arb_wb_fifo
    import reg_writeback_arb_pkg::*;
#(
    parameter int unsigned DEPTH = WB_FIFO_DEPTH
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              push,
    input  logic [WB_ADDR_W-1:0]              push_addr,
    input  logic [WB_DATA_W-1:0]              push_data,
    input  logic                              pop,
    output logic [WB_ADDR_W-1:0]              head_addr,
    output logic [WB_DATA_W-1:0]              head_data,
    output logic                              empty,
    output logic [$clog2(DEPTH):0]            count,
    output logic [DEPTH-1:0]                  entry_valid,
    output logic [DEPTH-1:0][WB_ADDR_W-1:0]   entry_addr
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    wb_entry_t       mem_q [DEPTH];
    wb_entry_t       mem_d [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{addr: push_addr, data: push_data};
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_addr = mem_q[rd_ptr_q].addr;
    assign head_data = mem_q[rd_ptr_q].data;
    assign empty     = (count_q == '0);
    assign count     = count_q;

    // Slot i is live when its distance from the read pointer is below the fill level.
    always_comb begin
        logic [PtrW-1:0] offset;
        offset      = '0;
        entry_valid = '0;
        entry_addr  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset         = PtrW'(i) - rd_ptr_q;
            entry_valid[i] = ({1'b0, offset} < count_q);
            entry_addr[i]  = mem_q[i].addr;
        end
    end

endmodule

// File: rtl/reg_writeback_arb.sv
// Regfile writeback arbiter: ALU stream has priority, loads are buffered and
// forced through after a bounded wait; also reports pending-write hazards.
module reg_writeback_arb
    import reg_writeback_arb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = WB_FIFO_DEPTH,
    parameter int unsigned STARVE_LIM = WB_STARVE_LIM
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_valid,
    input  logic [6:0]  alu_addr,
    input  logic [63:0] alu_data,
    output logic        alu_stall,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [6:0]  ld_addr,
    input  logic [63:0] ld_data,
    input  logic [6:0]  addr_a,
    input  logic [6:0]  addr_b,
    output logic        busy_a,
    output logic        busy_b,
    output logic [6:0]  addr_c,
    output logic [63:0] regport_c,
    output logic        write_regc
);

    localparam int unsigned PtrW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW    = PtrW + 1;
    localparam int unsigned StarveW = $clog2(STARVE_LIM + 1);

    logic                                  fifo_push;
    logic                                  fifo_pop;
    logic                                  fifo_empty;
    logic [CntW-1:0]                       fifo_count;
    logic [WB_ADDR_W-1:0]                  head_addr;
    logic [WB_DATA_W-1:0]                  head_data;
    logic [FIFO_DEPTH-1:0]                 entry_valid;
    logic [FIFO_DEPTH-1:0][WB_ADDR_W-1:0]  entry_addr;

    logic                 force_load;
    wb_sel_e              sel;
    logic [StarveW-1:0]   starve_cnt_q, starve_cnt_d;
    logic [WB_ADDR_W-1:0] addr_c_q, addr_c_d;
    logic [WB_DATA_W-1:0] data_c_q, data_c_d;
    logic                 write_c_q, write_c_d;

    reg_writeback_arb_wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (fifo_push),
        .push_addr   (ld_addr),
        .push_data   (ld_data),
        .pop         (fifo_pop),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .empty       (fifo_empty),
        .count       (fifo_count),
        .entry_valid (entry_valid),
        .entry_addr  (entry_addr)
    );

    // Ready depends on the current fill only, so a same-cycle pop never frees a slot early.
    assign ld_ready  = (fifo_count < CntW'(FIFO_DEPTH));
    assign fifo_push = ld_valid && ld_ready;

    assign force_load = (starve_cnt_q == StarveW'(STARVE_LIM)) && !fifo_empty;
    assign alu_stall  = force_load;

    always_comb begin
        sel = SelNone;
        if (force_load) begin
            sel = SelLoad;
        end else if (alu_valid) begin
            sel = SelAlu;
        end else if (!fifo_empty) begin
            sel = SelLoad;
        end
    end

    assign fifo_pop = (sel == SelLoad);

    always_comb begin
        addr_c_d  = addr_c_q;
        data_c_d  = data_c_q;
        write_c_d = 1'b0;
        unique case (sel)
            SelAlu: begin
                addr_c_d  = alu_addr;
                data_c_d  = alu_data;
                write_c_d = 1'b1;
            end
            SelLoad: begin
                addr_c_d  = head_addr;
                data_c_d  = head_data;
                write_c_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (fifo_empty || fifo_pop) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != StarveW'(STARVE_LIM)) begin
            starve_cnt_d = starve_cnt_q + StarveW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt_q <= '0;
            addr_c_q     <= '0;
            data_c_q     <= '0;
            write_c_q    <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            addr_c_q     <= addr_c_d;
            data_c_q     <= data_c_d;
            write_c_q    <= write_c_d;
        end
    end

    assign addr_c     = addr_c_q;
    assign regport_c  = data_c_q;
    assign write_regc = write_c_q;

    // A register is busy while a load for it is buffered or its write is on the port.
    always_comb begin
        busy_a = write_c_q && (addr_c_q == addr_a);
        busy_b = write_c_q && (addr_c_q == addr_b);
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (entry_valid[i] && (entry_addr[i] == addr_a)) busy_a = 1'b1;
            if (entry_valid[i] && (entry_addr[i] == addr_b)) busy_b = 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_writeback_arb.sv
// Directed bench for reg_writeback_arb: one task per scenario, inline checks.
module tb_reg_writeback_arb;

    logic        clk;
    logic        reset;
    logic        alu_valid;
    logic [6:0]  alu_addr;
    logic [63:0] alu_data;
    logic        alu_stall;
    logic        ld_valid;
    logic        ld_ready;
    logic [6:0]  ld_addr;
    logic [63:0] ld_data;
    logic [6:0]  addr_a;
    logic [6:0]  addr_b;
    logic        busy_a;
    logic        busy_b;
    logic [6:0]  addr_c;
    logic [63:0] regport_c;
    logic        write_regc;

    int total;
    int bad;

    reg_writeback_arb #(
        .FIFO_DEPTH (4),
        .STARVE_LIM (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .alu_valid  (alu_valid),
        .alu_addr   (alu_addr),
        .alu_data   (alu_data),
        .alu_stall  (alu_stall),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .addr_a     (addr_a),
        .addr_b     (addr_b),
        .busy_a     (busy_a),
        .busy_b     (busy_b),
        .addr_c     (addr_c),
        .regport_c  (regport_c),
        .write_regc (write_regc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue-side protocol: an ALU write must never target a register with a buffered load.
    always @(negedge clk) begin
        if (!reset && alu_valid) begin
            for (int i = 0; i < 4; i++) begin
                if (dut.u_fifo.entry_valid[i] && dut.u_fifo.entry_addr[i] == alu_addr) begin
                    bad++;
                    $display("FAIL alu_protocol: alu_addr=%0d hits buffered load", alu_addr);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0;
        alu_addr  = '0;
        alu_data  = '0;
        ld_valid  = 1'b0;
        ld_addr   = '0;
        ld_data   = '0;
        addr_a    = '0;
        addr_b    = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        tick();
        tick();
        total++;
        if ({write_regc, addr_c, regport_c} !== 72'h0) begin
            bad++;
            $display("FAIL reset_out: got %h want 0", {write_regc, addr_c, regport_c});
        end
        total++;
        if ({ld_ready, busy_a, busy_b, alu_stall} !== 4'b1000) begin
            bad++;
            $display("FAIL reset_flags: got %b want 1000", {ld_ready, busy_a, busy_b, alu_stall});
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_alu_only();
        alu_valid = 1'b1;
        alu_addr  = 7'd3;
        alu_data  = 64'hDEAD;
        tick();
        total++;
        if ({write_regc, addr_c, regport_c} !== {1'b1, 7'd3, 64'hDEAD}) begin
            bad++;
            $display("FAIL alu_single: got %h want %h", {write_regc, addr_c, regport_c},
                     {1'b1, 7'd3, 64'hDEAD});
        end
        for (int i = 0; i < 4; i++) begin
            alu_addr = 7'(10 + i);
            alu_data = 64'(256 + i);
            tick();
            total++;
            if ({write_regc, addr_c, regport_c} !== {1'b1, 7'(10 + i), 64'(256 + i)}) begin
                bad++;
                $display("FAIL alu_b2b[%0d]: got %h want %h", i,
                         {write_regc, addr_c, regport_c}, {1'b1, 7'(10 + i), 64'(256 + i)});
            end
        end
        alu_valid = 1'b0;
        tick();
        total++;
        if ({write_regc, addr_c, regport_c} !== {1'b0, 7'd13, 64'd259}) begin
            bad++;
            $display("FAIL alu_hold: got %h want %h", {write_regc, addr_c, regport_c},
                     {1'b0, 7'd13, 64'd259});
        end
        idle();
        tick();
    endtask

    task automatic test_load_fill();
        alu_valid = 1'b1;
        alu_addr  = 7'd30;
        alu_data  = 64'h30;
        for (int i = 1; i <= 4; i++) begin
            ld_valid = 1'b1;
            ld_addr  = 7'(i);
            ld_data  = 64'h1000 + 64'(i);
            tick();
        end
        ld_addr = 7'd5;
        ld_data = 64'h1005;
        addr_a  = 7'd2;
        settle();
        total++;
        if ({ld_ready, busy_a} !== 2'b01) begin
            bad++;
            $display("FAIL fill_full: got ready,busy_a=%b want 01", {ld_ready, busy_a});
        end
        tick();
        alu_valid = 1'b0;
        settle();
        total++;
        if (ld_ready !== 1'b0) begin
            bad++;
            $display("FAIL fill_pop_no_ready: got %b want 0", ld_ready);
        end
        tick();
        total++;
        if (ld_ready !== 1'b1) begin
            bad++;
            $display("FAIL fill_ready_after_pop: got %b want 1", ld_ready);
        end
        for (int i = 1; i <= 5; i++) begin
            total++;
            if ({write_regc, addr_c, regport_c} !== {1'b1, 7'(i), 64'h1000 + 64'(i)}) begin
                bad++;
                $display("FAIL fill_order[%0d]: got %h want %h", i,
                         {write_regc, addr_c, regport_c}, {1'b1, 7'(i), 64'h1000 + 64'(i)});
            end
            tick();
            ld_valid = 1'b0;
        end
        total++;
        if ({write_regc, busy_a} !== 2'b00) begin
            bad++;
            $display("FAIL fill_drained: got we,busy_a=%b want 00", {write_regc, busy_a});
        end
        idle();
        tick();
    endtask

    task automatic test_starve();
        alu_valid = 1'b1;
        alu_addr  = 7'd20;
        alu_data  = 64'h2000;
        ld_valid  = 1'b1;
        ld_addr   = 7'd9;
        ld_data   = 64'hAAAA;
        tick();
        ld_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            alu_data = 64'h2000 + 64'(k);
            settle();
            total++;
            if ({alu_stall, write_regc, addr_c, regport_c} !==
                {1'b0, 1'b1, 7'd20, 64'h2000 + 64'(k - 1)}) begin
                bad++;
                $display("FAIL starve_wait[%0d]: got %h want %h", k,
                         {alu_stall, write_regc, addr_c, regport_c},
                         {1'b0, 1'b1, 7'd20, 64'h2000 + 64'(k - 1)});
            end
            tick();
        end
        alu_data = 64'h2009;
        settle();
        total++;
        if (alu_stall !== 1'b1) begin
            bad++;
            $display("FAIL starve_stall: got %b want 1", alu_stall);
        end
        tick();
        total++;
        if ({alu_stall, write_regc, addr_c, regport_c} !== {1'b0, 1'b1, 7'd9, 64'hAAAA}) begin
            bad++;
            $display("FAIL starve_forced: got %h want %h", {alu_stall, write_regc, addr_c,
                     regport_c}, {1'b0, 1'b1, 7'd9, 64'hAAAA});
        end
        tick();
        total++;
        if ({write_regc, addr_c, regport_c} !== {1'b1, 7'd20, 64'h2009}) begin
            bad++;
            $display("FAIL starve_held_alu: got %h want %h", {write_regc, addr_c, regport_c},
                     {1'b1, 7'd20, 64'h2009});
        end
        idle();
        tick();
        tick();
    endtask

    task automatic test_full_concurrent();
        logic [6:0] got [8];
        int         n;
        int         next;
        int         budget;
        logic       fire;
        n         = 0;
        alu_valid = 1'b1;
        alu_addr  = 7'd40;
        alu_data  = 64'h40;
        ld_valid  = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            ld_addr = 7'((i > 5) ? 5 : i);
            ld_data = 64'h3000 + 64'((i > 5) ? 5 : i);
            tick();
        end
        settle();
        total++;
        if ({alu_stall, ld_ready} !== 2'b10) begin
            bad++;
            $display("FAIL full_force: got stall,ready=%b want 10", {alu_stall, ld_ready});
        end
        tick();
        total++;
        if ({write_regc, addr_c, regport_c, ld_ready} !== {1'b1, 7'd1, 64'h3001, 1'b1}) begin
            bad++;
            $display("FAIL full_forced_pop: got %h want %h", {write_regc, addr_c, regport_c,
                     ld_ready}, {1'b1, 7'd1, 64'h3001, 1'b1});
        end
        tick();
        alu_valid = 1'b0;
        ld_addr   = 7'd6;
        ld_data   = 64'h3006;
        settle();
        total++;
        if ({write_regc, addr_c, ld_ready} !== {1'b1, 7'd40, 1'b0}) begin
            bad++;
            $display("FAIL full_refilled: got %h want %h", {write_regc, addr_c, ld_ready},
                     {1'b1, 7'd40, 1'b0});
        end
        next   = 6;
        budget = 0;
        while (n < 7 && budget < 40) begin
            ld_valid = (next <= 8);
            ld_addr  = 7'(next);
            ld_data  = 64'h3000 + 64'(next);
            settle();
            fire = ld_valid && ld_ready;
            tick();
            if (fire) next++;
            if (write_regc && addr_c >= 7'd1 && addr_c <= 7'd8) begin
                got[n] = addr_c;
                n++;
            end
            budget++;
        end
        total++;
        if (n != 7) begin
            bad++;
            $display("FAIL full_drain_count: got %0d writes want 7", n);
        end
        for (int j = 0; j < n; j++) begin
            total++;
            if (got[j] !== 7'(j + 2)) begin
                bad++;
                $display("FAIL full_wrap_order[%0d]: got r%0d want r%0d", j, got[j], j + 2);
            end
        end
        idle();
        tick();
        tick();
    endtask

    task automatic test_hazard();
        addr_a   = 7'd6;
        addr_b   = 7'd7;
        ld_valid = 1'b1;
        ld_addr  = 7'd7;
        ld_data  = 64'h7777;
        settle();
        total++;
        if (busy_b !== 1'b0) begin
            bad++;
            $display("FAIL hazard_input_excluded: got %b want 0", busy_b);
        end
        tick();
        ld_valid = 1'b0;
        settle();
        total++;
        if ({busy_a, busy_b} !== 2'b01) begin
            bad++;
            $display("FAIL hazard_buffered: got a,b=%b want 01", {busy_a, busy_b});
        end
        tick();
        total++;
        if ({write_regc, addr_c, regport_c, busy_b} !== {1'b1, 7'd7, 64'h7777, 1'b1}) begin
            bad++;
            $display("FAIL hazard_inflight: got %h want %h", {write_regc, addr_c, regport_c,
                     busy_b}, {1'b1, 7'd7, 64'h7777, 1'b1});
        end
        tick();
        total++;
        if ({write_regc, busy_b} !== 2'b00) begin
            bad++;
            $display("FAIL hazard_clear: got we,busy_b=%b want 00", {write_regc, busy_b});
        end
        idle();
        tick();
    endtask

    task automatic test_mid_reset();
        alu_valid = 1'b1;
        alu_addr  = 7'd30;
        alu_data  = 64'h33;
        ld_valid  = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            ld_addr = 7'(i);
            ld_data = 64'h5000 + 64'(i);
            tick();
        end
        idle();
        addr_a = 7'd1;
        addr_b = 7'd3;
        reset  = 1'b1;
        tick();
        total++;
        if ({write_regc, ld_ready, busy_a, busy_b} !== 4'b0100) begin
            bad++;
            $display("FAIL midreset_state: got we,rdy,a,b=%b want 0100",
                     {write_regc, ld_ready, busy_a, busy_b});
        end
        reset = 1'b0;
        tick();
        tick();
        total++;
        if ({write_regc, busy_a, busy_b} !== 3'b000) begin
            bad++;
            $display("FAIL midreset_discard: got we,a,b=%b want 000", {write_regc, busy_a, busy_b});
        end
        alu_valid = 1'b1;
        alu_addr  = 7'd5;
        alu_data  = 64'h11;
        tick();
        alu_valid = 1'b0;
        total++;
        if ({write_regc, addr_c, regport_c} !== {1'b1, 7'd5, 64'h11}) begin
            bad++;
            $display("FAIL midreset_first_alu: got %h want %h", {write_regc, addr_c, regport_c},
                     {1'b1, 7'd5, 64'h11});
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (write_regc !== 1'b0) begin
                bad++;
                $display("FAIL midreset_alone[%0d]: got %b want 0", i, write_regc);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_alu_only();
        test_load_fill();
        test_starve();
        test_full_concurrent();
        test_hazard();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
